// File: rtl/pll_ctrl.sv
// ECP5 EHXPLLL wrapper for the 25 MHz reference: lock filtering, lock-qualified
// system reset and a request/acknowledge controller for dynamic phase stepping.
module pll_ctrl #(
  parameter int          NUM_OUT     = 2,
  parameter int          CLKI_DIV    = 1,
  parameter int          CLKFB_DIV   = 16,
  parameter logic [27:0] OUT_DIV     = {7'd1, 7'd1, 7'd8, 7'd8},
  parameter logic [27:0] OUT_CPHASE  = {7'd0, 7'd0, 7'd9, 7'd7},
  parameter int          LOCK_FILTER = 1024,
  parameter int          STEP_HIGH   = 4,
  parameter int          STEP_SETTLE = 8
) (
  input  logic               clk25,
  input  logic               rst_n,
  output logic [NUM_OUT-1:0] pll_clk,
  output logic               locked,
  output logic               sys_rst_n,
  input  logic               step_valid,
  output logic               step_ready,
  input  logic [1:0]         step_chan,
  input  logic               step_dir,
  input  logic [7:0]         step_count,
  output logic               step_done,
  output logic               step_err
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, DONE} state_t;

  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] LOCK_MAX    = 16'(LOCK_FILTER);
  localparam logic [7:0]  HIGH_LAST   = 8'(STEP_HIGH - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(STEP_SETTLE - 1);

  state_t      state;
  logic [7:0]  timer;
  logic [7:0]  remaining;
  logic [1:0]  chan;
  logic [1:0]  phase_sel;
  logic        phase_dir;
  logic        phase_step;
  logic        phase_loadreg;
  logic        pll_rst;
  logic        pll_lock;
  logic        lock_meta;
  logic        lock_sync;
  logic [15:0] lock_cnt;
  logic        chan_bad;

  function automatic logic [1:0] chan_to_sel(input logic [1:0] ch);
    case (ch)
      2'd0:    chan_to_sel = 2'b11;
      2'd1:    chan_to_sel = 2'b00;
      2'd2:    chan_to_sel = 2'b01;
      2'd3:    chan_to_sel = 2'b10;
      default: chan_to_sel = 2'b11;
    endcase
  endfunction

  assign pll_rst       = ~rst_n;
  assign phase_loadreg = 1'b0;
  assign step_ready    = (state == IDLE) & locked;
  assign chan_bad      = {1'b0, chan} >= 3'(NUM_OUT);

`ifdef SYNTHESIS
  logic [3:0] clk_all;
  logic [3:0] clk_en;
  logic       clk_intfb;

  for (genvar i = 0; i < 4; i++) begin : g_en
    assign clk_en[i] = (i < NUM_OUT) ? 1'b1 : 1'b0;
  end

  EHXPLLL #(
    .PLLRST_ENA      ("ENABLED"),
    .INTFB_WAKE      ("DISABLED"),
    .STDBY_ENABLE    ("DISABLED"),
    .DPHASE_SOURCE   ("ENABLED"),
    .OUTDIVIDER_MUXA ("DIVA"),
    .OUTDIVIDER_MUXB ("DIVB"),
    .OUTDIVIDER_MUXC ("DIVC"),
    .OUTDIVIDER_MUXD ("DIVD"),
    .CLKI_DIV        (CLKI_DIV),
    .CLKFB_DIV       (CLKFB_DIV),
    .FEEDBK_PATH     (NUM_OUT < 3 ? "INT_OS2" : "INT_OP"),
    .CLKOP_ENABLE    ("ENABLED"),
    .CLKOP_DIV       (int'(OUT_DIV[6:0])),
    .CLKOP_CPHASE    (int'(OUT_CPHASE[6:0])),
    .CLKOP_FPHASE    (0),
    .CLKOS_ENABLE    ("ENABLED"),
    .CLKOS_DIV       (int'(OUT_DIV[13:7])),
    .CLKOS_CPHASE    (int'(OUT_CPHASE[13:7])),
    .CLKOS_FPHASE    (0),
    .CLKOS2_ENABLE   ("ENABLED"),
    .CLKOS2_DIV      (int'(OUT_DIV[20:14])),
    .CLKOS2_CPHASE   (int'(OUT_CPHASE[20:14])),
    .CLKOS3_ENABLE   ("ENABLED"),
    .CLKOS3_DIV      (int'(OUT_DIV[27:21])),
    .CLKOS3_CPHASE   (int'(OUT_CPHASE[27:21]))
  ) u_pll (
    .CLKI         (clk25),
    .CLKFB        (clk_intfb),
    .PHASESEL1    (phase_sel[1]),
    .PHASESEL0    (phase_sel[0]),
    .PHASEDIR     (phase_dir),
    .PHASESTEP    (phase_step),
    .PHASELOADREG (phase_loadreg),
    .STDBY        (1'b0),
    .PLLWAKESYNC  (1'b0),
    .RST          (pll_rst),
    .ENCLKOP      (clk_en[0]),
    .ENCLKOS      (clk_en[1]),
    .ENCLKOS2     (clk_en[2]),
    .ENCLKOS3     (clk_en[3]),
    .CLKOP        (clk_all[0]),
    .CLKOS        (clk_all[1]),
    .CLKOS2       (clk_all[2]),
    .CLKOS3       (clk_all[3]),
    .LOCK         (pll_lock),
    .INTLOCK      (),
    .REFCLK       (),
    .CLKINTFB     (clk_intfb)
  );

  assign pll_clk = clk_all[NUM_OUT-1:0];
`else
  // Behavioural stand-in for the hard PLL: reference clock on every output, lock follows reset.
  logic pll_ports_unused;
  assign pll_clk  = {NUM_OUT{clk25}};
  assign pll_lock = ~pll_rst;
  assign pll_ports_unused = ^{phase_sel, phase_dir, phase_step, phase_loadreg,
                              OUT_DIV, OUT_CPHASE, 32'(CLKI_DIV), 32'(CLKFB_DIV)};
`endif

  // Lock synchroniser, saturating qualification counter and derived reset.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      lock_cnt  <= 16'd0;
      locked    <= 1'b0;
      sys_rst_n <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
      if (!lock_sync) begin
        lock_cnt <= 16'd0;
      end else if (lock_cnt != LOCK_MAX) begin
        lock_cnt <= lock_cnt + 16'd1;
      end else begin
        lock_cnt <= lock_cnt;
      end
      locked    <= lock_sync && (lock_cnt >= LOCK_LAST);
      sys_rst_n <= locked;
    end
  end

  // Phase-step request controller; SEL/DIR are captured at accept and held.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= 8'd0;
      remaining  <= 8'd0;
      chan       <= 2'd0;
      phase_sel  <= 2'b00;
      phase_dir  <= 1'b0;
      phase_step <= 1'b0;
      step_done  <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      step_done <= 1'b0;
      step_err  <= 1'b0;
      if ((state == SETUP || state == PULSE || state == SETTLE) && !lock_sync) begin
        // Lock lost: abandon the remaining steps and report the failure.
        state      <= DONE;
        phase_step <= 1'b0;
        remaining  <= 8'd0;
        timer      <= 8'd0;
        step_done  <= 1'b1;
        step_err   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (step_valid && step_ready) begin
              state     <= SETUP;
              timer     <= 8'd0;
              chan      <= step_chan;
              phase_sel <= chan_to_sel(step_chan);
              phase_dir <= step_dir;
              remaining <= step_count;
            end
          end
          SETUP: begin
            if (timer == 8'd1) begin
              timer <= 8'd0;
              if (chan_bad) begin
                state     <= DONE;
                step_done <= 1'b1;
                step_err  <= 1'b1;
              end else if (remaining == 8'd0) begin
                state     <= DONE;
                step_done <= 1'b1;
              end else begin
                state      <= PULSE;
                phase_step <= 1'b1;
              end
            end else begin
              timer <= timer + 8'd1;
            end
          end
          PULSE: begin
            if (timer == HIGH_LAST) begin
              state      <= SETTLE;
              timer      <= 8'd0;
              phase_step <= 1'b0;
            end else begin
              timer <= timer + 8'd1;
            end
          end
          SETTLE: begin
            if (timer == SETTLE_LAST) begin
              timer     <= 8'd0;
              remaining <= remaining - 8'd1;
              if (remaining == 8'd1) begin
                state     <= DONE;
                step_done <= 1'b1;
              end else begin
                state      <= PULSE;
                phase_step <= 1'b1;
              end
            end else begin
              timer <= timer + 8'd1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state      <= IDLE;
            phase_step <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_ctrl.sv
// Scoreboard bench for pll_ctrl: requests push expected completions, a monitor
// pops them when step_done appears and checks timing, error flag and pulse activity.
module tb_pll_ctrl;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pll_clk;
  logic       locked;
  logic       sys_rst_n;
  logic       step_valid = 1'b0;
  logic       step_ready;
  logic [1:0] step_chan = 2'd0;
  logic       step_dir = 1'b0;
  logic [7:0] step_count = 8'd0;
  logic       step_done;
  logic       step_err;

  always #20 clk25 = ~clk25;

  pll_ctrl dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .pll_clk    (pll_clk),
    .locked     (locked),
    .sys_rst_n  (sys_rst_n),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_chan  (step_chan),
    .step_dir   (step_dir),
    .step_count (step_count),
    .step_done  (step_done),
    .step_err   (step_err)
  );

  typedef struct {
    int         cycle;
    logic       err;
    int         pulses;
    int         high;
    logic [1:0] sel;
    logic       dir;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulse_cnt = 0;
  int   high_cnt = 0;

  always @(posedge clk25) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts PHASESTEP activity and retires one expectation per step_done.
  initial begin
    logic step_q;
    exp_t e;
    step_q = 1'b0;
    forever begin
      @(negedge clk25);
      if (dut.phase_step === 1'b1) begin
        high_cnt++;
        if (!step_q) pulse_cnt++;
      end
      step_q = dut.phase_step;
      if (step_err === 1'b1) check("err_with_done", step_done, 1);
      if (step_done === 1'b1) begin
        if (sbq.size() == 0) begin
          check("done_without_request", step_done, 0);
        end else begin
          e = sbq.pop_front();
          check("done_cycle", cyc, e.cycle);
          check("done_err", step_err, e.err);
          check("pulse_count", pulse_cnt, e.pulses);
          check("step_high_cycles", high_cnt, e.high);
          check("phase_sel", dut.phase_sel, e.sel);
          check("phase_dir", dut.phase_dir, e.dir);
        end
        pulse_cnt = 0;
        high_cnt  = 0;
      end
    end
  end

  task automatic do_req(input logic [1:0] ch, input logic d, input logic [7:0] n,
                        input int lat, input logic err, input int pulses, input int high,
                        input logic [1:0] sel, output int acc);
    exp_t e;
    int   guard;
    guard = 0;
    while (step_ready !== 1'b1 && guard < 3000) begin
      @(posedge clk25); #1;
      guard++;
    end
    check("ready_before_req", step_ready, 1);
    step_valid = 1'b1;
    step_chan  = ch;
    step_dir   = d;
    step_count = n;
    acc        = cyc;
    e.cycle = cyc + lat; e.err = err; e.pulses = pulses;
    e.high  = high;      e.sel = sel; e.dir    = d;
    sbq.push_back(e);
    @(posedge clk25); #1;
    step_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 500) begin
      @(posedge clk25); #1;
      guard++;
    end
    check("done_seen_in_time", sbq.size(), 0);
    sbq.delete();
    @(posedge clk25); #1;
  endtask

  task automatic lock_up(input int t0);
    int guard;
    guard = 0;
    while (locked !== 1'b1 && guard < 2000) begin
      @(negedge clk25);
      guard++;
    end
    check("locked_rise_cycle", cyc, t0 + 1026);
    check("sys_rst_n_lags_locked", sys_rst_n, 0);
    check("ready_with_locked", step_ready, 1);
    @(negedge clk25);
    check("sys_rst_n_rise", sys_rst_n, 1);
    @(posedge clk25); #1;
  endtask

  initial begin
    int acc;
    int t0;
    int guard;
    force dut.pll_lock = 1'b0;
    repeat (3) @(posedge clk25);
    #1;
    check("rst_pll_rst", dut.pll_rst, 1);
    check("rst_locked", locked, 0);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_ready", step_ready, 0);
    check("rst_done", step_done, 0);
    rst_n = 1'b1;

    // Lock comes up 10 cycles after reset release.
    t0 = cyc + 10;
    while (cyc != t0) begin
      @(posedge clk25); #1;
    end
    force dut.pll_lock = 1'b1;
    check("pll_rst_released", dut.pll_rst, 0);
    lock_up(t0);

    // Normal 3-step lag on CLKOS; a stray valid while busy must be ignored.
    do_req(2'd1, 1'b0, 8'd3, 39, 1'b0, 3, 12, 2'b00, acc);
    check("ready_low_busy", step_ready, 0);
    step_valid = 1'b1; step_chan = 2'd0; step_count = 8'd0;
    repeat (2) @(posedge clk25);
    #1;
    step_valid = 1'b0;
    wait_empty();

    do_req(2'd0, 1'b1, 8'd0, 3, 1'b0, 0, 0, 2'b11, acc);
    wait_empty();
    do_req(2'd3, 1'b0, 8'd5, 3, 1'b1, 0, 0, 2'b10, acc);
    wait_empty();
    do_req(2'd2, 1'b1, 8'd1, 3, 1'b1, 0, 0, 2'b01, acc);
    wait_empty();
    do_req(2'd0, 1'b1, 8'd1, 15, 1'b0, 1, 4, 2'b11, acc);
    wait_empty();

    // Lock loss during the second pulse of a 10-step request.
    do_req(2'd1, 1'b0, 8'd10, 18, 1'b1, 2, 7, 2'b00, acc);
    while (cyc != acc + 15) begin
      @(posedge clk25); #1;
    end
    force dut.pll_lock = 1'b0;
    guard = 0;
    while (locked !== 1'b0 && guard < 50) begin
      @(negedge clk25);
      guard++;
    end
    check("locked_fall_cycle", cyc, acc + 18);
    check("step_low_on_abort", dut.phase_step, 0);
    wait_empty();
    repeat (20) @(posedge clk25);
    #1;
    check("ready_low_unlocked", step_ready, 0);
    check("sys_rst_n_low_unlocked", sys_rst_n, 0);

    t0 = cyc;
    force dut.pll_lock = 1'b1;
    lock_up(t0);
    do_req(2'd1, 1'b1, 8'd2, 27, 1'b0, 2, 8, 2'b00, acc);
    wait_empty();

    // Asynchronous reset in the middle of a pulse: everything drops, no completion.
    do_req(2'd1, 1'b0, 8'd3, 39, 1'b0, 3, 12, 2'b00, acc);
    sbq.delete();
    guard = 0;
    while (dut.phase_step !== 1'b1 && guard < 50) begin
      @(posedge clk25); #1;
      guard++;
    end
    check("pulse_before_reset", dut.phase_step, 1);
    @(negedge clk25);
    #5;
    rst_n = 1'b0;
    #1;
    check("arst_step", dut.phase_step, 0);
    check("arst_locked", locked, 0);
    check("arst_sys_rst_n", sys_rst_n, 0);
    check("arst_ready", step_ready, 0);
    check("arst_pll_rst", dut.pll_rst, 1);
    repeat (20) @(posedge clk25);
    #1;
    check("arst_no_done", step_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
